// File: rtl/soul_hit_if.sv
// soul_hit_if: bullet/soul inputs and hit status outputs
// shared between the game logic (master) and soul_hit_detector (slave).
interface soul_hit_if;
  logic        frame_tick;
  logic        isRun;
  logic [15:0] soul_pos;
  logic [15:0] soul_size;
  logic        soul_moving;
  logic [15:0] position1;
  logic [15:0] position2;
  logic [15:0] size1;
  logic [15:0] size2;
  logic [2:0]  color1;
  logic [2:0]  color2;
  logic        isRender1;
  logic        isRender2;
  logic        isCollide;
  logic [7:0]  hp;
  logic        is_dead;
  logic        hit_flash;

  modport master (
    output frame_tick, isRun,
    output soul_pos, soul_size, soul_moving,
    output position1, position2,
    output size1, size2,
    output color1, color2,
    output isRender1, isRender2,
    input  isCollide, hp, is_dead, hit_flash
  );

  modport slave (
    input  frame_tick, isRun,
    input  soul_pos, soul_size, soul_moving,
    input  position1, position2,
    input  size1, size2,
    input  color1, color2,
    input  isRender1, isRender2,
    output isCollide, hp, is_dead, hit_flash
  );
endinterface

// File: rtl/soul_hit_detector.sv
// soul_hit_detector: soul/bullet overlap, HP and i-frame FSM.
// Optional blink output enabled by SOUL_HIT_FLASH_EN.
module soul_hit_detector #(
  parameter int HP_MAX       = 20,
  parameter int DMG          = 4,
  parameter int HEAL         = 1,
  parameter int IFRAME_TICKS = 30
) (
  input logic      clk,
  input logic      reset,
  soul_hit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, ARMED, INVULN, DEAD
  } state_t;

  typedef enum logic [1:0] {
    FX_NONE, FX_DMG, FX_HEAL
  } fx_t;

  localparam logic [7:0] HP_MAX_B = 8'(HP_MAX);
  localparam logic [7:0] DMG_B    = 8'(DMG);
  localparam logic [7:0] HEAL_B   = 8'(HEAL);
  localparam logic [7:0] IFR_B    = 8'(IFRAME_TICKS);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [7:0] hp, hp_n;
  logic       col, col_n;

  logic       ov1, ov2;
  fx_t        fx1, fx2, fx;
  logic [8:0] heal_sum;
  logic [7:0] hp_heal, hp_dmg;

  // 9-bit edge sums so boxes near 255 cannot wrap
  function automatic logic overlap(
    input logic [15:0] sp,
    input logic [15:0] ss,
    input logic [15:0] bp,
    input logic [15:0] bs,
    input logic        rend
  );
    logic [8:0] sx, sy, bx, by;
    logic [8:0] sxe, sye, bxe, bye;
    logic       nz;
    sx  = {1'b0, sp[15:8]};
    sy  = {1'b0, sp[7:0]};
    bx  = {1'b0, bp[15:8]};
    by  = {1'b0, bp[7:0]};
    sxe = sx + {1'b0, ss[15:8]};
    sye = sy + {1'b0, ss[7:0]};
    bxe = bx + {1'b0, bs[15:8]};
    bye = by + {1'b0, bs[7:0]};
    nz  = (ss[15:8] != 8'd0) && (ss[7:0] != 8'd0) &&
          (bs[15:8] != 8'd0) && (bs[7:0] != 8'd0);
    return rend && nz &&
           (sx < bxe) && (bx < sxe) &&
           (sy < bye) && (by < sye);
  endfunction

  function automatic fx_t effect(
    input logic       hit,
    input logic [2:0] color,
    input logic       moving
  );
    fx_t f;
    f = FX_NONE;
    if (hit) begin
      case (color)
        3'b000:  f = FX_DMG;
        3'b001:  f = FX_HEAL;
        3'b010:  f = moving ? FX_DMG : FX_NONE;
        default: f = FX_NONE;
      endcase
    end
    return f;
  endfunction

  // per-slot effect, slot 1 has priority, saturating HP math
  always_comb begin
    ov1 = overlap(bus.soul_pos, bus.soul_size,
                  bus.position1, bus.size1, bus.isRender1);
    ov2 = overlap(bus.soul_pos, bus.soul_size,
                  bus.position2, bus.size2, bus.isRender2);
    fx1 = effect(ov1, bus.color1, bus.soul_moving);
    fx2 = effect(ov2, bus.color2, bus.soul_moving);
    fx  = (fx1 != FX_NONE) ? fx1 : fx2;
    heal_sum = {1'b0, hp} + {1'b0, HEAL_B};
    hp_heal  = (heal_sum > {1'b0, HP_MAX_B}) ?
               HP_MAX_B : heal_sum[7:0];
    hp_dmg   = (hp > DMG_B) ? (hp - DMG_B) : 8'd0;
  end

  // next state; IDLE with isRun high on a tick arms and
  // evaluates that same tick so a hit is not lost
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hp_n    = hp;
    col_n   = 1'b0;
    if (bus.frame_tick) begin
      unique case (state)
        IDLE, ARMED: begin
          if (!bus.isRun) begin
            state_n = IDLE;
            cnt_n   = 8'd0;
          end else begin
            state_n = ARMED;
            unique case (fx)
              FX_DMG: begin
                hp_n  = hp_dmg;
                col_n = 1'b1;
                if (hp_dmg == 8'd0) begin
                  state_n = DEAD;
                  cnt_n   = 8'd0;
                end else begin
                  state_n = INVULN;
                  cnt_n   = IFR_B;
                end
              end
              FX_HEAL: begin
                hp_n  = hp_heal;
                col_n = 1'b1;
              end
              default: ;
            endcase
          end
        end
        INVULN: begin
          if (!bus.isRun) begin
            state_n = IDLE;
            cnt_n   = 8'd0;
          end else begin
            if (fx == FX_HEAL) begin
              hp_n  = hp_heal;
              col_n = 1'b1;
            end
            if (cnt <= 8'd1) begin
              state_n = ARMED;
              cnt_n   = 8'd0;
            end else begin
              cnt_n = cnt - 8'd1;
            end
          end
        end
        DEAD: ;
        default: state_n = IDLE;
      endcase
    end
  end

  // state, counter, HP and pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
      hp    <= HP_MAX_B;
      col   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hp    <= hp_n;
      col   <= col_n;
    end
  end

  assign bus.isCollide = col;
  assign bus.hp        = hp;
  assign bus.is_dead   = (state == DEAD);

`ifdef SOUL_HIT_FLASH_EN
  logic       flash;
  logic [1:0] fcnt;

  // blink starts lit on i-frame entry, flips every 4th tick
  always_ff @(posedge clk) begin
    if (reset) begin
      flash <= 1'b0;
      fcnt  <= 2'd0;
    end else if (state_n != INVULN) begin
      flash <= 1'b0;
      fcnt  <= 2'd0;
    end else if (state != INVULN) begin
      flash <= 1'b1;
      fcnt  <= 2'd0;
    end else if (bus.frame_tick) begin
      fcnt <= fcnt + 2'd1;
      if (fcnt == 2'd3) flash <= ~flash;
    end
  end

  assign bus.hit_flash = flash & (state == INVULN);
`else
  assign bus.hit_flash = 1'b0;
`endif

endmodule
